// File: rtl/vga_regbank_feeder.sv
// vga_regbank_feeder
// Transmit side of the VGA display-register load interface. On each falling
// edge of VSync it walks display addresses FIRST_ADDR..LAST_ADDR, reads each
// byte from the clock/timer register file over src_req/src_ack and presents
// it to the VGA pointer unit with a one-cycle CS_DATA strobe.
// Optional build macro: VGA_FEEDER_BCD_CHECK_EN drops non-BCD bytes for
// addresses 1-9 and raises the sticky bcd_err flag.
//
// Handshake: src_req is held high, with src_addr stable, until a cycle in
// which src_ack=1; src_data is taken in that same cycle. src_ack seen while
// src_req=0 is ignored. CS_DATA is a single-cycle push with no back-pressure;
// MemAddrOUT/MemDataOUT are 0 whenever CS_DATA is 0.
module vga_regbank_feeder #(
    parameter logic [3:0] FIRST_ADDR  = 4'd1,
    parameter logic [3:0] LAST_ADDR   = 4'd12,
    parameter int         ACK_TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       VSync,
    output logic       src_req,
    output logic [3:0] src_addr,
    input  logic       src_ack,
    input  logic [7:0] src_data,
    output logic       CS_DATA,
    output logic [3:0] MemAddrOUT,
    output logic [7:0] MemDataOUT,
    output logic       frame_done,
    output logic       abort,
    output logic       timeout_err,
    output logic       bcd_err,
    output logic [1:0] dbgState
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ARMED = 2'd0,
        REQ   = 2'd1,
        PUSH  = 2'd2,
        DONE  = 2'd3
    } feederState_t;

    feederState_t state;
    feederState_t nextState;
    logic          vsyncQ;
    logic [3:0]    addr;
    logic [TW-1:0] timer;
    logic [7:0]    dataQ;
    logic          timeoutErr;

    logic startFrame;
    logic advance;
    logic holdReq;
    logic latchData;
    logic setTimeout;
    logic clrTimeout;
    logic bcdBad;

    // Falling edge of VSync opens the load window; a level already low at
    // reset release does not count because vsyncQ resets to 0.
    assign startFrame = vsyncQ & ~VSync;

`ifdef VGA_FEEDER_BCD_CHECK_EN
    // Addresses 1-9 carry packed BCD; either nibble above 9 marks a bad byte.
    assign bcdBad = (addr >= 4'd1) && (addr <= 4'd9) &&
                    ((src_data[7:4] > 4'd9) || (src_data[3:0] > 4'd9));
`else
    assign bcdBad = 1'b0;
`endif

    // Next-state and output decode; NEXT is folded into the REQ/PUSH exits.
    always_comb begin
        nextState  = state;
        advance    = 1'b0;
        holdReq    = 1'b0;
        latchData  = 1'b0;
        setTimeout = 1'b0;
        clrTimeout = 1'b0;
        src_req    = 1'b0;
        CS_DATA    = 1'b0;
        frame_done = 1'b0;
        abort      = 1'b0;
        case (state)
            ARMED: begin
                if (startFrame) begin
                    clrTimeout = 1'b1;
                    nextState  = REQ;
                end
            end
            REQ: begin
                src_req = 1'b1;
                if (VSync) begin
                    abort     = 1'b1;
                    nextState = ARMED;
                end else if (src_ack) begin
                    latchData = 1'b1;
                    if (bcdBad) begin
                        advance = 1'b1;
                    end else begin
                        nextState = PUSH;
                    end
                end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                    setTimeout = 1'b1;
                    advance    = 1'b1;
                end else begin
                    holdReq = 1'b1;
                end
            end
            PUSH: begin
                if (VSync) begin
                    abort     = 1'b1;
                    nextState = ARMED;
                end else begin
                    CS_DATA = 1'b1;
                    advance = 1'b1;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                nextState  = ARMED;
            end
            default: nextState = ARMED;
        endcase
        if (advance) begin
            nextState = (addr == LAST_ADDR) ? DONE : REQ;
        end
    end

    // State, address walk, ack timer, captured byte and timeout flag.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ARMED;
            vsyncQ     <= 1'b0;
            addr       <= FIRST_ADDR;
            timer      <= '0;
            dataQ      <= '0;
            timeoutErr <= 1'b0;
        end else begin
            state  <= nextState;
            vsyncQ <= VSync;
            timer  <= holdReq ? timer + TW'(1) : '0;
            if (latchData) begin
                dataQ <= src_data;
            end
            if (state == ARMED && startFrame) begin
                addr <= FIRST_ADDR;
            end else if (advance && addr != LAST_ADDR) begin
                addr <= addr + 4'd1;
            end
            if (clrTimeout) begin
                timeoutErr <= 1'b0;
            end else if (setTimeout) begin
                timeoutErr <= 1'b1;
            end
        end
    end

`ifdef VGA_FEEDER_BCD_CHECK_EN
    logic bcdErrQ;

    // Sticky BCD error; only RESET clears it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bcdErrQ <= 1'b0;
        end else if (latchData && bcdBad) begin
            bcdErrQ <= 1'b1;
        end
    end

    assign bcd_err = bcdErrQ;
`else
    assign bcd_err = 1'b0;
`endif

    assign timeout_err = timeoutErr;
    assign src_addr    = src_req ? addr : 4'd0;
    assign MemAddrOUT  = CS_DATA ? addr : 4'd0;
    assign MemDataOUT  = CS_DATA ? dataQ : 8'd0;
    assign dbgState    = state;

endmodule

// File: tb/tb_vga_regbank_feeder.sv
// tb_vga_regbank_feeder
// Directed frames against vga_regbank_feeder: full frame, slow ack, ack
// timeout, VSync abort, reset mid-frame and the BCD byte case (its expected
// result follows VGA_FEEDER_BCD_CHECK_EN). A register-file responder answers
// src_req; a monitor pops the expected queue on every CS_DATA strobe.
module tb_vga_regbank_feeder;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       VSync;
    logic       src_req;
    logic [3:0] src_addr;
    logic       src_ack;
    logic [7:0] src_data;
    logic       CS_DATA;
    logic [3:0] MemAddrOUT;
    logic [7:0] MemDataOUT;
    logic       frame_done;
    logic       abort;
    logic       timeout_err;
    logic       bcd_err;
    logic [1:0] dbgState;

    vga_regbank_feeder dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .VSync       (VSync),
        .src_req     (src_req),
        .src_addr    (src_addr),
        .src_ack     (src_ack),
        .src_data    (src_data),
        .CS_DATA     (CS_DATA),
        .MemAddrOUT  (MemAddrOUT),
        .MemDataOUT  (MemDataOUT),
        .frame_done  (frame_done),
        .abort       (abort),
        .timeout_err (timeout_err),
        .bcd_err     (bcd_err),
        .dbgState    (dbgState)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 CLK = ~CLK;

    int cycleCnt = 0;
    always @(posedge CLK) cycleCnt++;

    // ---------------- scoreboard state ----------------
    logic [11:0] exp_q[$];
    int checkCnt = 0;
    int passCnt  = 0;

    int strobeCnt        = 0;
    int lastStrobeCycle  = -1;
    int firstStrobeCycle = -1;
    int expGap           = 0;
    int frameDoneCnt     = 0;
    int frameDoneCycle   = -1;
    int abortCnt         = 0;

    // responder configuration
    logic [7:0] memData[16];
    bit         tieAck    = 1'b0;
    int         ackDelay  = 0;
    logic [3:0] skipAddr  = 4'hF;
    bit         prevReq   = 1'b0;
    logic [3:0] prevAddr  = 4'h0;
    int         reqAge    = 0;

    task automatic check(input string name, input int act, input int req);
        checkCnt++;
        if (act == req) begin
            passCnt++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- register-file responder ----------------
    // Acks after ackDelay held cycles; data is only meaningful on the ack cycle.
    always @(negedge CLK) begin
        if (src_req) begin
            if (!prevReq || src_addr != prevAddr) reqAge = 0;
            else reqAge++;
        end
        prevReq  = src_req;
        prevAddr = src_addr;
        if (tieAck) src_ack = 1'b1;
        else src_ack = src_req && (src_addr != skipAddr) && (reqAge == ackDelay);
        src_data = (src_ack && src_req) ? memData[src_addr] : 8'hEE;
    end

    // ---------------- monitor ----------------
    always @(negedge CLK) begin
        logic [11:0] w;
        if (CS_DATA) begin
            strobeCnt++;
            if (lastStrobeCycle < 0) firstStrobeCycle = cycleCnt;
            else if (expGap != 0) check("strobe_gap", cycleCnt - lastStrobeCycle, expGap);
            lastStrobeCycle = cycleCnt;
            if (exp_q.size() == 0) begin
                checkCnt++;
                $display("FAIL unexpected_strobe actual=%0h_%0h required=none", MemAddrOUT, MemDataOUT);
            end else begin
                w = exp_q.pop_front();
                check("strobe_word", {20'd0, MemAddrOUT, MemDataOUT}, {20'd0, w});
            end
        end else begin
            check("idle_outputs_zero", {20'd0, MemAddrOUT, MemDataOUT}, 0);
        end
        if (frame_done) begin
            frameDoneCnt++;
            frameDoneCycle = cycleCnt;
        end
        if (abort) abortCnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic pushFrame(input int skip);
        for (int a = 1; a <= 12; a++) begin
            if (a != skip) exp_q.push_back({4'(a), memData[a]});
        end
    endtask

    // VSync high for one edge, then low; p is the counter value before the
    // edge that detects the falling edge.
    task automatic startFrame(output int p);
        @(posedge CLK); #1 VSync = 1'b1;
        @(posedge CLK); #1 VSync = 1'b0;
        p = cycleCnt;
        lastStrobeCycle  = -1;
        firstStrobeCycle = -1;
    endtask

    task automatic waitDone(input int budget, input string name);
        int fd0 = frameDoneCnt;
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge CLK); #1;
            if (frameDoneCnt != fd0) got = 1'b1;
        end
        check(name, int'(got), 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int p;
        int s0;
        int fd0;
        int ab0;
        int busy;
        bit found;

        for (int a = 0; a < 16; a++) memData[a] = 8'(8'h10 + a);
        RESET    = 1'b1;
        VSync    = 1'b0;
        src_ack  = 1'b0;
        src_data = 8'h00;

        // reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_cs_data", int'(CS_DATA), 0);
        check("rst_src_req", int'(src_req), 0);
        check("rst_src_addr", int'(src_addr), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_abort", int'(abort), 0);
        check("rst_timeout_err", int'(timeout_err), 0);
        check("rst_bcd_err", int'(bcd_err), 0);
        check("rst_state", int'(dbgState), 0);
        RESET = 1'b0;
        repeat (3) @(posedge CLK);
        #1 check("idle_low_vsync_no_req", int'(src_req), 0);

        // 1: full frame, ack tied high (also high while src_req=0)
        tieAck = 1'b1; expGap = 2;
        pushFrame(0);
        s0 = strobeCnt;
        startFrame(p);
        waitDone(100, "full_frame_done");
        check("full_frame_done_cycle", frameDoneCycle, p + 25);
        check("full_first_strobe_cycle", firstStrobeCycle, p + 2);
        check("full_strobe_count", strobeCnt - s0, 12);
        check("full_queue_empty", exp_q.size(), 0);
        tieAck = 1'b0;

        // 2: slow ack, 3 cycles after req -> 4 req cycles + 1 push per word
        ackDelay = 3; expGap = 5;
        pushFrame(0);
        startFrame(p);
        waitDone(200, "slow_frame_done");
        check("slow_frame_done_cycle", frameDoneCycle, p + 61);
        check("slow_queue_empty", exp_q.size(), 0);

        // 3: address 5 never acked -> 15 req cycles then skipped
        ackDelay = 0; expGap = 0; skipAddr = 4'd5;
        pushFrame(5);
        s0 = strobeCnt;
        startFrame(p);
        waitDone(200, "timeout_frame_done");
        check("timeout_frame_done_cycle", frameDoneCycle, p + 38);
        check("timeout_err_set", int'(timeout_err), 1);
        check("timeout_strobe_count", strobeCnt - s0, 11);
        check("timeout_queue_empty", exp_q.size(), 0);
        skipAddr = 4'hF; expGap = 2;
        pushFrame(0);
        startFrame(p);
        repeat (3) @(negedge CLK);
        #1 check("timeout_err_cleared", int'(timeout_err), 0);
        waitDone(100, "after_timeout_frame_done");
        check("after_timeout_done_cycle", frameDoneCycle, p + 25);

        // 4: VSync rises during REQ of address 7
        ackDelay = 3; expGap = 5;
        for (int a = 1; a <= 6; a++) exp_q.push_back({4'(a), memData[a]});
        fd0 = frameDoneCnt; ab0 = abortCnt; s0 = strobeCnt;
        startFrame(p);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge CLK); #1;
            if (src_req && src_addr == 4'd7) found = 1'b1;
        end
        check("abort_reached_addr7", int'(found), 1);
        @(posedge CLK); #1 VSync = 1'b1;
        repeat (20) @(negedge CLK);
        #1;
        check("abort_pulse_count", abortCnt - ab0, 1);
        check("abort_no_frame_done", frameDoneCnt - fd0, 0);
        check("abort_strobe_count", strobeCnt - s0, 6);
        check("abort_queue_empty", exp_q.size(), 0);
        check("abort_req_dropped", int'(src_req), 0);
        check("abort_state_armed", int'(dbgState), 0);
        ackDelay = 0; expGap = 2;
        pushFrame(0);
        startFrame(p);
        waitDone(100, "restart_frame_done");
        check("restart_first_strobe_cycle", firstStrobeCycle, p + 2);
        check("restart_queue_empty", exp_q.size(), 0);

        // 5: reset asserted during PUSH of address 3
        pushFrame(0);
        startFrame(p);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge CLK); #1;
            if (CS_DATA && MemAddrOUT == 4'd3) found = 1'b1;
        end
        check("reset_reached_push3", int'(found), 1);
        RESET = 1'b1;
        #1;
        check("reset_cs_data", int'(CS_DATA), 0);
        check("reset_src_req", int'(src_req), 0);
        check("reset_mem_addr", int'(MemAddrOUT), 0);
        check("reset_mem_data", int'(MemDataOUT), 0);
        check("reset_unsent_words", exp_q.size(), 9);
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        s0 = strobeCnt; busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK); #1;
            if (src_req) busy++;
        end
        check("reset_release_no_req", busy, 0);
        check("reset_release_no_strobe", strobeCnt - s0, 0);
        pushFrame(0);
        startFrame(p);
        waitDone(100, "after_reset_frame_done");
        check("after_reset_done_cycle", frameDoneCycle, p + 25);

        // 6: non-BCD byte at address 2, raw 8'hFF at address 12
        memData[2] = 8'h5A; memData[12] = 8'hFF; expGap = 0;
`ifdef VGA_FEEDER_BCD_CHECK_EN
        pushFrame(2);
`else
        pushFrame(0);
`endif
        startFrame(p);
        waitDone(100, "bcd_frame_done");
        check("bcd_queue_empty", exp_q.size(), 0);
`ifdef VGA_FEEDER_BCD_CHECK_EN
        check("bcd_err_set", int'(bcd_err), 1);
`else
        check("bcd_err_tied_low", int'(bcd_err), 0);
`endif

        repeat (5) @(negedge CLK);
        #1 check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
